fast_dac_interleaver: RTL and testbench
=======================================

# fast_dac_interleaver

Parametrised successor to the fixed 14-channel fast-DAC driver. Drives `N_DAC` dual-channel parallel DACs from `2*N_DAC` signed streams. Each DAC bus is time-interleaved with a per-DAC select line. Adds four things the fixed driver lacks: frame-coherent pair capture, per-channel saturating offset trim, per-channel mute, and a single-channel (non-interleaved) mode. It sits between the servo/filter outputs and the DAC output pins/ODDR stage.

## Interface
- `N_DAC`, 7, number of dual-channel DAC buses (1..16).
- `W`, 16, sample and DAC word width.
- `OFS_W`, 16, signed offset width; must satisfy `OFS_W <= W`.
- `clk_in`  in  1  sample/DAC clock. The only clock. All logic is on its rising edge.
- `rst_in`  in  1  reset; synchronous, active-high.
- `s_in`  in  `2*N_DAC*W`  signed input samples. Channel c occupies `s_in[c*W +: W]`. Channel 2k is side A of DAC k; channel 2k+1 is side B.
- `mute_in`  in  `2*N_DAC`  per-channel mute. Bit c set forces channel c output to 0.
- `mode_in`  in  1  operating mode. 0 = interleaved A/B; 1 = A-only, B channels unused.
- `ofs_we_in`  in  1  offset write strobe.
- `ofs_addr_in`  in  `$clog2(2*N_DAC)`  offset channel index.
- `ofs_data_in`  in  `OFS_W`  signed offset value.
- `dac_out`  out  `N_DAC*W`  DAC k data bus at `dac_out[k*W +: W]`.
- `sel_out`  out  `N_DAC`  DAC k channel select. 0 = A, 1 = B.
- `frame_out`  out  1  high in the cycle `dac_out` presents side-A words of a new frame.

## Operation
- `phase_q` is a 1-bit frame phase counter. Reset sets it to 0. It toggles every cycle while `mode_q`=0 and is held at 0 while `mode_q`=1.
- `mode_q` loads `mode_in` only at edges where `phase_q`=1, or any edge if `mode_q`=1. Mode changes therefore land on frame boundaries.
- **Capture stage**
  - Enabled at edges where `phase_q`=0.
  - `cap[c] <= s_in` channel c, for all channels simultaneously.
  - A and B are therefore coherent: both come from the same input sample.
- **Process stage**
  - Enabled at edges where `phase_q`=1 (mode 0), or every edge (mode 1).
  - `proc[c] <= mute_q[c] ? 0 : sat(cap[c] + ofs[c])`.
  - The sum is computed at W+1 bits after sign-extending `ofs`.
  - `sat` clamps to [-2^(W-1), 2^(W-1)-1]; for W=16 that is [-32768, 32767].
  - `mute_in` is registered to `mute_q` at the capture edge.
- **Output stage**
  - Mode 0, edge with `phase_q`=0: `dac_out[k] <= proc[2k]`, `sel_out <= 0`, `frame_out <= 1`.
  - Mode 0, edge with `phase_q`=1: `dac_out[k] <= proc[2k+1]`, `sel_out <= all ones`, `frame_out <= 0`.
  - Mode 1: every edge `dac_out[k] <= proc[2k]`, `sel_out <= 0`, `frame_out <= 1`.
- **Offset RAM**
  - `ofs[0..2N_DAC-1]` is a register array written when `ofs_we_in`=1.
  - Writes take effect from the next process-stage update.
  - `ofs_addr_in >= 2*N_DAC` is ignored; no register changes.
  - A write in the same cycle as a process update is not used by that update; the old value is applied.
- **Reset** (synchronous, all state):
  - `phase_q`=0, `mode_q`=0, `cap`=0, `proc`=0, `ofs`=0, `mute_q`=0.
  - `dac_out`=0, `sel_out`=0, `frame_out`=0.
  - `rst_in` asserted mid-frame abandons the partial frame.
  - The first post-reset capture occurs at the first edge with `rst_in` low.

## Timing
- Mode 0 frame is 2 cycles. Capture at edge E0 (`phase_q`=0), process at E1, side A on `dac_out` after E2, side B after E3.
- Mode 0 latency from capture edge: 2 cycles for side A, 3 for side B.
- Mode 0 throughput: one coherent sample set per 2 cycles. `s_in` values presented while `phase_q`=1 are not captured.
- Mode 1: capture every edge, latency 2 cycles, throughput 1 sample per cycle. `sel_out` is held 0.
- `sel_out` and `dac_out` change on the same edge, with no skew within this block.
- The output register is the last stage; there is no combinational path from inputs to outputs.
- `frame_out` is registered and aligned with the side-A word.

## Test plan
- **Reset/idle.** Hold `rst_in`=1 for 3 cycles with `s_in` all 0x7FFF.
  - Outputs all 0, `frame_out`=0.
  - After release, side A = 0x7FFF appears at the 3rd edge (E2).
- **Interleave coherence.** N_DAC=7. Channel c = c*0x100 when `phase_q`=0 and 0x5555 when `phase_q`=1.
  - `dac_out[k]` alternates 2k*0x100 (sel=0) and (2k+1)*0x100 (sel=1).
  - 0x5555 never appears.
- **Saturation.**
  - Channel 3 = 0x7F00 with ofs[3]=+0x0200 → side B of DAC 1 = 0x7FFF.
  - Channel 0 = 0x8100 with ofs[0]=-0x0200 → side A of DAC 0 = 0x8000.
  - ofs=+5 on 0x0010 → 0x0015.
- **Mute and bad address.**
  - `mute_in[5]`=1 → DAC 2 side B = 0 while other channels pass.
  - A write to address 14 (N_DAC=7) leaves all offsets unchanged.
- **Mode switch.** Assert `mode_in`=1 in a `phase_q`=0 cycle.
  - The current B word still outputs with sel=1.
  - After that, `sel_out`=0 constantly and side A updates every cycle with 2-cycle latency.
  - Switching back resumes alternation starting with side A and `frame_out`=1.
- **Reset mid-frame.** Assert `rst_in` for one cycle right after a side-A output.
  - The next cycle shows 0, not side B.
  - The pipeline refills with the first post-reset capture.

Source files
------------

// File: rtl/fast_dac_interleaver.sv
// fast_dac_interleaver
// Drives N_DAC dual-channel parallel DACs from 2*N_DAC signed sample streams.
// Each DAC bus is time-interleaved A/B with a per-DAC select line.
// Pipeline: capture (coherent A/B pair) -> process (offset trim, saturate,
// mute) -> output register.
// Mode 0 runs a two-cycle frame with side A then side B on the bus.
// Mode 1 streams side A every cycle with select held low.
module fast_dac_interleaver #(
   parameter int N_DAC = 7,
   parameter int W     = 16,
   parameter int OFS_W = 16
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [2*N_DAC*W-1:0]         s_in,
   input  logic [2*N_DAC-1:0]           mute_in,
   input  logic                         mode_in,
   input  logic                         ofs_we_in,
   input  logic [$clog2(2*N_DAC)-1:0]   ofs_addr_in,
   input  logic [OFS_W-1:0]             ofs_data_in,
   output logic [N_DAC*W-1:0]           dac_out,
   output logic [N_DAC-1:0]             sel_out,
   output logic                         frame_out
);

   localparam int NCH = 2 * N_DAC;
   localparam int AW  = $clog2(NCH);

   // Adds a sign-extended offset to a sample at W+1 bits and clamps the
   // result back into the signed W-bit range.
   function automatic logic signed [W-1:0] sat_add(
      input logic signed [W-1:0]     a,
      input logic signed [OFS_W-1:0] b
   );
      logic signed [W:0] a_x;
      logic signed [W:0] b_x;
      logic signed [W:0] sum;
      a_x = {a[W-1], a};
      b_x = {{(W + 1 - OFS_W){b[OFS_W-1]}}, b};
      sum = a_x + b_x;
      // The two top bits disagree only when the W-bit range was exceeded.
      if (sum[W] != sum[W-1]) begin
         if (sum[W]) begin
            sat_add = {1'b1, {(W - 1){1'b0}}};
         end else begin
            sat_add = {1'b0, {(W - 1){1'b1}}};
         end
      end else begin
         sat_add = sum[W-1:0];
      end
   endfunction

   // Frame control
   logic phase_q, phase_d;
   logic mode_q, mode_d;
   logic cap_en;
   logic proc_en;
   logic a_side;

   // Pipeline state
   logic signed [W-1:0]     cap_q  [NCH];
   logic [NCH-1:0]          mute_q;
   logic signed [W-1:0]     proc_q [NCH];
   logic signed [W-1:0]     proc_d [NCH];
   logic signed [OFS_W-1:0] ofs_q  [NCH];

   // Output registers
   logic [N_DAC*W-1:0] dac_q, dac_d;
   logic [N_DAC-1:0]   sel_q, sel_d;
   logic               frame_q, frame_d;

   // Stage enables and next phase/mode; mode only moves on a frame boundary.
   always_comb begin
      cap_en  = ~phase_q;
      proc_en = phase_q | mode_q;
      a_side  = mode_q | ~phase_q;
      phase_d = mode_q ? 1'b0 : ~phase_q;
      mode_d  = (phase_q | mode_q) ? mode_in : mode_q;
   end

   // Frame phase and mode registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         phase_q <= 1'b0;
         mode_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         mode_q  <= mode_d;
      end
   end

   // ---- capture stage: whole sample set and its mute mask taken together ----
   // Capture all channels at once so A and B of a DAC come from one sample.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int c = 0; c < NCH; c++) begin
            cap_q[c] <= '0;
         end
         mute_q <= '0;
      end else if (cap_en) begin
         for (int c = 0; c < NCH; c++) begin
            cap_q[c] <= $signed(s_in[c*W +: W]);
         end
         mute_q <= mute_in;
      end
   end

   // Offset register file; addresses beyond the last channel match nothing.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int c = 0; c < NCH; c++) begin
            ofs_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (ofs_we_in && (ofs_addr_in == AW'(c))) begin
               ofs_q[c] <= $signed(ofs_data_in);
            end
         end
      end
   end

   // ---- process stage: trim, saturate, mute ----
   // Per-channel trimmed value; a same-cycle offset write is not seen here.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         proc_d[c] = '0;
         if (!mute_q[c]) begin
            proc_d[c] = sat_add(cap_q[c], ofs_q[c]);
         end
      end
   end

   // Process register, updated once per frame in mode 0 and every cycle in mode 1.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int c = 0; c < NCH; c++) begin
            proc_q[c] <= '0;
         end
      end else if (proc_en) begin
         for (int c = 0; c < NCH; c++) begin
            proc_q[c] <= proc_d[c];
         end
      end
   end

   // ---- output stage: pick side A or B for every DAC bus ----
   // Select the side for this cycle; data, select and frame move together.
   always_comb begin
      dac_d = '0;
      for (int k = 0; k < N_DAC; k++) begin
         dac_d[k*W +: W] = a_side ? proc_q[2*k] : proc_q[2*k+1];
      end
      sel_d   = a_side ? '0 : '1;
      frame_d = a_side;
   end

   // Output register, the only thing driving the pins.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         dac_q   <= '0;
         sel_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         dac_q   <= dac_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
      end
   end

   assign dac_out   = dac_q;
   assign sel_out   = sel_q;
   assign frame_out = frame_q;

endmodule

// File: tb/tb_fast_dac_interleaver.sv
// Scoreboard bench for fast_dac_interleaver (N_DAC=7, W=16, OFS_W=16).
// Stimulus pushes hand-derived expected outputs tagged with the clock edge
// after which they must be visible; a monitor compares on every falling edge.
module tb_fast_dac_interleaver;

   localparam int ND  = 7;
   localparam int W   = 16;
   localparam int NCH = 14;
   localparam int AW  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [NCH*W-1:0]    s_in;
   logic [NCH-1:0]      mute;
   logic                mode;
   logic                we;
   logic [AW-1:0]       addr;
   logic [W-1:0]        odata;
   logic [ND*W-1:0]     dac;
   logic [ND-1:0]       sel;
   logic                frame;

   fast_dac_interleaver #(.N_DAC(ND), .W(W), .OFS_W(16)) dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .s_in        (s_in),
      .mute_in     (mute),
      .mode_in     (mode),
      .ofs_we_in   (we),
      .ofs_addr_in (addr),
      .ofs_data_in (odata),
      .dac_out     (dac),
      .sel_out     (sel),
      .frame_out   (frame)
   );

   typedef struct {
      int              tag;
      logic [ND*W-1:0] dac;
      logic [ND-1:0]   sel;
      logic            frm;
      logic [95:0]     nm;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   ecnt   = 0;
   int   n_vec  = 0;
   int   n_fail = 0;

   // Mode-switch scenario: source frame and side per edge 1..15 (0 = zero data).
   int   sw_src [16] = '{0, 0, 0, 1, 1, 3, 3, 5, 5, 7, 8, 9, 10, 10, 12, 12};
   bit   sw_b   [16] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1};

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic expect_at(input int ahead, input logic [ND*W-1:0] d,
                            input logic [ND-1:0] s, input logic f,
                            input logic [95:0] nm);
      exp_t e;
      e.tag = ecnt + ahead;
      e.dac = d;
      e.sel = s;
      e.frm = f;
      e.nm  = nm;
      expq.push_back(e);
   endtask

   function automatic logic [ND*W-1:0] lanes(input int base, input int step, input int off);
      logic [ND*W-1:0] r;
      r = '0;
      for (int k = 0; k < ND; k++) begin
         r[k*W +: W] = 16'(base + (2*k + off) * step);
      end
      return r;
   endfunction

   task automatic drive_s(input int base, input int step);
      for (int c = 0; c < NCH; c++) begin
         s_in[c*W +: W] = 16'(base + c * step);
      end
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      we   = 1'b0;
      mute = '0;
      mode = 1'b0;
      expect_at(1, '0, '0, 1'b0, "rst_out");
      tick();
      rst = 1'b0;
   endtask

   // Monitor: compare every entry due at the current edge.
   always @(negedge clk) begin
      while (expq.size() > 0 && expq[0].tag <= ecnt) begin
         mon_e = expq.pop_front();
         n_vec++;
         if (mon_e.tag != ecnt) begin
            n_fail++;
            $display("FAIL %s: check for edge %0d not reached in time (now %0d)",
                     mon_e.nm, mon_e.tag, ecnt);
         end else if (dac !== mon_e.dac || sel !== mon_e.sel || frame !== mon_e.frm) begin
            n_fail++;
            $display("FAIL %s edge %0d: got dac=%h sel=%h frame=%b, want dac=%h sel=%h frame=%b",
                     mon_e.nm, ecnt, dac, sel, frame, mon_e.dac, mon_e.sel, mon_e.frm);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (edge %0d)", ecnt);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [ND*W-1:0] a1, b1, a2, b2;

      // Reset/idle: three reset edges with full-scale input, then first frame.
      rst = 1'b1; mode = 1'b0; we = 1'b0; addr = '0; odata = '0; mute = '0;
      drive_s(16'h7FFF, 0);
      for (int i = 0; i < 3; i++) begin
         expect_at(1, '0, '0, 1'b0, "rst_hold");
         tick();
      end
      rst = 1'b0;
      expect_at(1, '0, '0, 1'b1, "idle_e0");
      tick();
      expect_at(1, '0, 7'h7F, 1'b0, "idle_e1");
      tick();
      expect_at(1, lanes(16'h7FFF, 0, 0), '0, 1'b1, "first_a");
      tick();
      expect_at(1, lanes(16'h7FFF, 0, 0), 7'h7F, 1'b0, "first_b");
      tick();

      // Interleave coherence: junk on phase-1 cycles must never be captured.
      do_reset();
      for (int f = 0; f < 4; f++) begin
         drive_s(f * 16'h10, 16'h100);
         expect_at(3, lanes(f * 16'h10, 16'h100, 0), '0, 1'b1, "coh_a");
         expect_at(4, lanes(f * 16'h10, 16'h100, 1), 7'h7F, 1'b0, "coh_b");
         tick();
         drive_s(16'h5555, 0);
         tick();
      end
      tick();
      tick();

      // Saturation, mute, bad address, same-cycle offset write.
      do_reset();
      drive_s(16'h5555, 0);
      we = 1'b1; addr = 4'd3;  odata = 16'h0200; tick();
      addr = 4'd0;  odata = 16'hFE00; tick();
      addr = 4'd6;  odata = 16'h0005; tick();
      addr = 4'd14; odata = 16'h1234; tick();
      we = 1'b0;
      drive_s(16'h1000, 1);
      s_in[0*W +: W] = 16'h8100;
      s_in[3*W +: W] = 16'h7F00;
      s_in[5*W +: W] = 16'h0505;
      s_in[6*W +: W] = 16'h0010;
      mute = 14'(1 << 5);
      a1 = lanes(16'h1000, 1, 0);
      a1[0*W +: W] = 16'h8000;
      a1[3*W +: W] = 16'h0015;
      b1 = lanes(16'h1000, 1, 1);
      b1[1*W +: W] = 16'h7FFF;
      b1[2*W +: W] = 16'h0000;
      expect_at(3, a1, '0, 1'b1, "sat_a");
      expect_at(4, b1, 7'h7F, 1'b0, "sat_mute_b");
      tick();
      // Offset write coinciding with the process update of the frame above.
      mute = '0;
      we = 1'b1; addr = 4'd2; odata = 16'h0100;
      drive_s(16'h5555, 0);
      tick();
      we = 1'b0;
      drive_s(16'h1000, 1);
      s_in[0*W +: W] = 16'h8100;
      s_in[3*W +: W] = 16'h7F00;
      s_in[5*W +: W] = 16'h0505;
      s_in[6*W +: W] = 16'h0010;
      a2 = a1;
      a2[1*W +: W] = 16'h1102;
      b2 = b1;
      b2[2*W +: W] = 16'h0505;
      expect_at(3, a2, '0, 1'b1, "ofs_late_a");
      expect_at(4, b2, 7'h7F, 1'b0, "unmute_b");
      tick();
      drive_s(16'h5555, 0);
      tick();
      tick();
      tick();

      // Mode switch into single-channel and back.
      do_reset();
      for (int e = 1; e <= 15; e++) begin
         mode = (e >= 5 && e <= 10);
         if (e == 2 || e == 4 || e == 6 || e == 13 || e == 15) begin
            drive_s(16'h5555, 0);
         end else begin
            drive_s(e << 8, 1);
         end
         expect_at(1, lanes(sw_src[e] << 8, (sw_src[e] != 0) ? 1 : 0, sw_b[e] ? 1 : 0),
                   sw_b[e] ? 7'h7F : 7'h00, !sw_b[e], "mode_sw");
         tick();
      end
      mode = 1'b0;

      // Reset for one cycle right after a side-A output.
      do_reset();
      drive_s(16'h2100, 1);
      expect_at(1, '0, '0, 1'b1, "mr_e1");
      tick();
      drive_s(16'h5555, 0);
      expect_at(1, '0, 7'h7F, 1'b0, "mr_e2");
      tick();
      drive_s(16'h2300, 1);
      expect_at(1, lanes(16'h2100, 1, 0), '0, 1'b1, "mr_a");
      tick();
      rst = 1'b1;
      drive_s(16'h2400, 1);
      expect_at(1, '0, '0, 1'b0, "mr_flush");
      tick();
      rst = 1'b0;
      drive_s(16'h2500, 1);
      expect_at(1, '0, '0, 1'b1, "mr_e0");
      tick();
      drive_s(16'h5555, 0);
      expect_at(1, '0, 7'h7F, 1'b0, "mr_e1b");
      tick();
      drive_s(16'h2700, 1);
      expect_at(1, lanes(16'h2500, 1, 0), '0, 1'b1, "mr_refill_a");
      tick();
      drive_s(16'h5555, 0);
      expect_at(1, lanes(16'h2500, 1, 1), 7'h7F, 1'b0, "mr_refill_b");
      tick();

      tick();
      tick();
      while (expq.size() > 0) begin
         mon_e = expq.pop_front();
         n_vec++;
         n_fail++;
         $display("FAIL %s: check for edge %0d never performed", mon_e.nm, mon_e.tag);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
